vga_timing_rx: RTL and testbench

//  Sink end of the on-board VGA pixel interface: consumes Hsync/Vsync/R/G/B on the pixel clock,

---
 rtl/video_timing_pkg.sv | 28 ++
 rtl/vga_timing_rx_if.sv | 36 +++
 rtl/vga_period_meter.sv | 61 ++++++
 rtl/vga_timing_rx.sv | 189 ++++++++++++++++++
 tb/tb_vga_timing_rx.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/video_timing_pkg.sv
// Shared VGA timing constants, receiver FSM state type and a saturating counter helper.
// Used by the vga_timing_rx receiver and its vga_period_meter sub-blocks.
package video_timing_pkg;

    localparam int CW          = 11;
    localparam int H_RES       = 1024;
    localparam int V_RES       = 768;
    localparam int H_ACT_OFS   = 296;
    localparam int V_ACT_OFS   = 35;
    localparam int LOCK_FRAMES = 2;
    localparam int H_TOTAL     = 1344;
    localparam int H_SYNC      = 136;
    localparam int V_TOTAL     = 806;
    localparam int V_SYNC      = 6;

    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } rx_state_t;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + CW'(1);
    endfunction

endpackage

// File: rtl/vga_timing_rx_if.sv
// VGA pixel bus into the receiver plus its measurement/capture outputs.
// master = video source / observer, slave = vga_timing_rx.
interface vga_timing_rx_if;
    import video_timing_pkg::*;

    logic          Hsync;
    logic          Vsync;
    logic [7:0]    R;
    logic [7:0]    G;
    logic [7:0]    B;
    logic          locked;
    logic [CW-1:0] h_total;
    logic [CW-1:0] v_total;
    logic [CW-1:0] h_sync_w;
    logic [CW-1:0] v_sync_w;
    logic          pix_valid;
    logic [CW-1:0] pix_x;
    logic [CW-1:0] pix_y;
    logic [23:0]   pix_rgb;
    logic          frame_done;
    logic [31:0]   frame_sum;
    logic [7:0]    err_cnt;

    modport master (
        output Hsync, Vsync, R, G, B,
        input  locked, h_total, v_total, h_sync_w, v_sync_w,
        input  pix_valid, pix_x, pix_y, pix_rgb, frame_done, frame_sum, err_cnt
    );

    modport slave (
        input  Hsync, Vsync, R, G, B,
        output locked, h_total, v_total, h_sync_w, v_sync_w,
        output pix_valid, pix_x, pix_y, pix_rgb, frame_done, frame_sum, err_cnt
    );

endinterface

// File: rtl/vga_period_meter.sv
// Sync-edge detector with period and low-width counters, counting i_tick events.
// Start = first tick at/after a falling edge of i_level; for H the tick is every clock.
module vga_period_meter
    import video_timing_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          i_tick,
    input  logic          i_level,
    output logic          o_start,
    output logic [CW-1:0] o_cnt,
    output logic [CW-1:0] o_period,
    output logic [CW-1:0] o_low_w
);

    logic          r_level_q;
    logic          r_pend;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_low;
    logic [CW-1:0] r_period;
    logic [CW-1:0] r_low_w;
    logic          w_fall;
    logic          w_rise;

    assign w_fall   = r_level_q & ~i_level;
    assign w_rise   = ~r_level_q & i_level;
    assign o_start  = i_tick & (r_pend | w_fall);
    assign o_cnt    = r_cnt;
    assign o_period = r_period;
    assign o_low_w  = r_low_w;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level_q <= 1'b1;
            r_pend    <= 1'b0;
            r_cnt     <= '0;
            r_low     <= '0;
            r_period  <= '0;
            r_low_w   <= '0;
        end else begin
            r_level_q <= i_level;
            if (o_start)
                r_pend <= 1'b0;
            else if (w_fall)
                r_pend <= 1'b1;
            if (o_start) begin
                r_cnt    <= '0;
                r_period <= sat_inc(r_cnt);
            end else if (i_tick) begin
                r_cnt <= sat_inc(r_cnt);
            end
            if (w_rise) begin
                r_low_w <= r_low;
                r_low   <= '0;
            end else if (i_tick && !i_level) begin
                r_low <= sat_inc(r_low);
            end
        end
    end

endmodule

// File: rtl/vga_timing_rx.sv
// VGA sink: measures line/frame timing, locks on a stable mode, recovers pixel coordinates.
// Define VGA_RX_CHECKSUM_EN to build the per-frame R+G+B checksum; otherwise frame_sum is 0.
module vga_timing_rx
    import video_timing_pkg::*;
#(
    parameter int P_H_RES       = H_RES,
    parameter int P_V_RES       = V_RES,
    parameter int P_H_ACT_OFS   = H_ACT_OFS,
    parameter int P_V_ACT_OFS   = V_ACT_OFS,
    parameter int P_LOCK_FRAMES = LOCK_FRAMES
)
(
    input  logic           clk,
    input  logic           reset,
    vga_timing_rx_if.slave vif
);

    localparam logic [CW-1:0] L_H_LO      = CW'(P_H_ACT_OFS);
    localparam logic [CW-1:0] L_H_HI      = CW'(P_H_ACT_OFS + P_H_RES);
    localparam logic [CW-1:0] L_V_LO      = CW'(P_V_ACT_OFS);
    localparam logic [CW-1:0] L_V_HI      = CW'(P_V_ACT_OFS + P_V_RES);
    localparam logic [7:0]    L_MATCH_TGT = 8'(P_LOCK_FRAMES - 1);

    logic          r_hs;
    logic          r_vs;
    logic [23:0]   r_rgb;
    logic          w_line_start;
    logic          w_frame_start;
    logic [CW-1:0] w_hcnt;
    logic [CW-1:0] w_vcnt;
    logic [CW-1:0] w_h_new;
    logic [CW-1:0] w_v_new;
    logic          w_timeout;
    logic          w_same;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hs  <= 1'b1;
            r_vs  <= 1'b1;
            r_rgb <= '0;
        end else begin
            r_hs  <= vif.Hsync;
            r_vs  <= vif.Vsync;
            r_rgb <= {vif.R, vif.G, vif.B};
        end
    end

    vga_period_meter u_hmeter (
        .clk      (clk),
        .rst      (reset),
        .i_tick   (1'b1),
        .i_level  (r_hs),
        .o_start  (w_line_start),
        .o_cnt    (w_hcnt),
        .o_period (vif.h_total),
        .o_low_w  (vif.h_sync_w)
    );

    vga_period_meter u_vmeter (
        .clk      (clk),
        .rst      (reset),
        .i_tick   (w_line_start),
        .i_level  (r_vs),
        .o_start  (w_frame_start),
        .o_cnt    (w_vcnt),
        .o_period (vif.v_total),
        .o_low_w  (vif.v_sync_w)
    );

    // Lengths that the meters are about to latch, used for same-cycle comparison.
    assign w_h_new   = sat_inc(w_hcnt);
    assign w_v_new   = sat_inc(w_vcnt);
    assign w_timeout = (w_hcnt == CNT_MAX);

    rx_state_t     r_state;
    rx_state_t     w_state_nxt;
    logic [7:0]    r_match;
    logic [CW-1:0] r_ref_h;
    logic [CW-1:0] r_ref_v;
    logic [7:0]    r_err;
    logic          w_lose;
    logic          w_valid;
    logic          w_frame_done;

    assign w_same = (w_h_new == r_ref_h) && (w_v_new == r_ref_v);

    always_comb begin
        w_state_nxt = r_state;
        w_lose      = 1'b0;
        if (w_timeout) begin
            w_state_nxt = SEARCH;
        end else begin
            case (r_state)
                SEARCH:
                    if (w_frame_start) w_state_nxt = MEASURE;
                MEASURE:
                    if (w_frame_start && w_same && (r_match + 8'd1) >= L_MATCH_TGT)
                        w_state_nxt = LOCKED;
                LOCKED:
                    if ((w_line_start && w_h_new != r_ref_h) ||
                        (w_frame_start && w_v_new != r_ref_v)) begin
                        w_state_nxt = SEARCH;
                        w_lose      = 1'b1;
                    end
                default:
                    w_state_nxt = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= SEARCH;
            r_match <= '0;
            r_ref_h <= '0;
            r_ref_v <= '0;
            r_err   <= '0;
        end else begin
            r_state <= w_state_nxt;
            // References freeze while locked and become the lock criteria.
            if (!w_timeout && w_frame_start && r_state != LOCKED) begin
                r_ref_h <= w_h_new;
                r_ref_v <= w_v_new;
                r_match <= (r_state == MEASURE && w_same) ? r_match + 8'd1 : 8'd0;
            end
            if (w_lose && r_err != 8'hFF)
                r_err <= r_err + 8'd1;
        end
    end

    assign w_valid = (r_state == LOCKED) && (w_state_nxt == LOCKED) &&
                     (w_hcnt >= L_H_LO) && (w_hcnt < L_H_HI) &&
                     (w_vcnt >= L_V_LO) && (w_vcnt < L_V_HI);
    assign w_frame_done = (r_state == LOCKED) && (w_state_nxt == LOCKED) && w_frame_start;

    logic          r_pix_valid;
    logic [CW-1:0] r_pix_x;
    logic [CW-1:0] r_pix_y;
    logic [23:0]   r_pix_rgb;
    logic          r_frame_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pix_valid  <= 1'b0;
            r_pix_x      <= '0;
            r_pix_y      <= '0;
            r_pix_rgb    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_pix_valid  <= w_valid;
            r_pix_x      <= w_valid ? w_hcnt - L_H_LO : '0;
            r_pix_y      <= w_valid ? w_vcnt - L_V_LO : '0;
            r_pix_rgb    <= w_valid ? r_rgb : '0;
            r_frame_done <= w_frame_done;
        end
    end

`ifdef VGA_RX_CHECKSUM_EN
    logic [31:0] r_acc;
    logic [31:0] r_sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc <= '0;
            r_sum <= '0;
        end else if (w_frame_done) begin
            r_sum <= r_acc;
            r_acc <= '0;
        end else if (w_valid) begin
            r_acc <= r_acc + 32'(r_rgb[23:16]) + 32'(r_rgb[15:8]) + 32'(r_rgb[7:0]);
        end else if (w_state_nxt != LOCKED) begin
            r_acc <= '0;
        end
    end

    assign vif.frame_sum = r_sum;
`else
    assign vif.frame_sum = '0;
`endif

    assign vif.locked     = (r_state == LOCKED);
    assign vif.pix_valid  = r_pix_valid;
    assign vif.pix_x      = r_pix_x;
    assign vif.pix_y      = r_pix_y;
    assign vif.pix_rgb    = r_pix_rgb;
    assign vif.frame_done = r_frame_done;
    assign vif.err_cnt    = r_err;

endmodule

// File: tb/tb_vga_timing_rx.sv
// Directed bench for vga_timing_rx on a scaled-down video mode (40-clk lines, 12-line frames,
// 16x6 active) so whole frames stay short; the counter width is the production width.
`timescale 1ns/1ps
module tb_vga_timing_rx;
    import video_timing_pkg::*;

    localparam int T_H_RES  = 16;
    localparam int T_V_RES  = 6;
    localparam int T_H_OFS  = 10;
    localparam int T_V_OFS  = 3;
    localparam int T_LINE   = 40;
    localparam int T_HSW    = 6;
    localparam int T_LINES  = 12;
    localparam int T_VSW    = 2;
`ifdef VGA_RX_CHECKSUM_EN
    localparam int EXP_SUM  = T_H_RES * T_V_RES * (1 + 2 + 3);
`else
    localparam int EXP_SUM  = 0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_mis = 0;

    vga_timing_rx_if vif();

    vga_timing_rx #(
        .P_H_RES       (T_H_RES),
        .P_V_RES       (T_V_RES),
        .P_H_ACT_OFS   (T_H_OFS),
        .P_V_ACT_OFS   (T_V_OFS),
        .P_LOCK_FRAMES (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .vif   (vif)
    );

    always #5 clk = ~clk;

    // Cumulative monitor counters; checks use deltas across a window.
    int          n_valid = 0;
    int          n_done = 0;
    int          n_c0 = 0;
    int          n_cn = 0;
    int          n_oob = 0;
    int          n_bad_rgb = 0;
    int          n_leak = 0;
    logic [31:0] last_sum = '0;

    always @(negedge clk) begin
        if (vif.pix_valid === 1'b1) begin
            n_valid++;
            if (vif.pix_x == 11'd0 && vif.pix_y == 11'd0) n_c0++;
            if (vif.pix_x == 11'(T_H_RES - 1) && vif.pix_y == 11'(T_V_RES - 1)) n_cn++;
            if (vif.pix_x >= 11'(T_H_RES) || vif.pix_y >= 11'(T_V_RES)) n_oob++;
            if (vif.pix_rgb !== 24'h010203) n_bad_rgb++;
        end else if (vif.pix_x != 11'd0 || vif.pix_y != 11'd0 || vif.pix_rgb != 24'd0) begin
            n_leak++;
        end
        if (vif.frame_done === 1'b1) begin
            n_done++;
            last_sum = vif.frame_sum;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive_line(input int len, input int stop, input bit vs_low);
        for (int c = 0; c < stop && c < len; c++) begin
            vif.Hsync = (c < T_HSW) ? 1'b0 : 1'b1;
            vif.Vsync = ~vs_low;
            @(posedge clk); #1;
        end
    endtask

    task automatic drive_frame(input int short_line);
        for (int l = 0; l < T_LINES; l++)
            drive_line((l == short_line) ? T_LINE - 1 : T_LINE, T_LINE, l < T_VSW);
    endtask

    task automatic idle(input int n);
        vif.Hsync = 1'b1;
        vif.Vsync = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    int b_valid, b_done, b_c0, b_cn;

    initial begin
        vif.Hsync = 1'b1;
        vif.Vsync = 1'b1;
        vif.R = 8'h01;
        vif.G = 8'h02;
        vif.B = 8'h03;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_locked",    32'(vif.locked), 0);
        check_eq("rst_pix_valid", 32'(vif.pix_valid), 0);
        check_eq("rst_h_total",   32'(vif.h_total), 0);
        check_eq("rst_v_total",   32'(vif.v_total), 0);
        check_eq("rst_err_cnt",   32'(vif.err_cnt), 0);
        check_eq("rst_frame_sum", vif.frame_sum, 0);
        reset = 1'b0;
        idle(5);

        // nominal timing: lock at the start of the third frame
        drive_frame(-1);
        drive_frame(-1);
        check_eq("lock_early", 32'(vif.locked), 0);
        drive_frame(-1);
        check_eq("lock_ok",  32'(vif.locked), 1);
        check_eq("h_total",  32'(vif.h_total), T_LINE);
        check_eq("v_total",  32'(vif.v_total), T_LINES);
        check_eq("h_sync_w", 32'(vif.h_sync_w), T_HSW);
        check_eq("v_sync_w", 32'(vif.v_sync_w), T_VSW);

        // full locked frame of constant colour
        b_valid = n_valid; b_done = n_done; b_c0 = n_c0; b_cn = n_cn;
        drive_frame(-1);
        check_eq("frm_valid_cnt", n_valid - b_valid, T_H_RES * T_V_RES);
        check_eq("frm_done_cnt",  n_done - b_done, 1);
        check_eq("frm_first_px",  n_c0 - b_c0, 1);
        check_eq("frm_last_px",   n_cn - b_cn, 1);
        check_eq("frm_sum",       last_sum, EXP_SUM);
        check_eq("frm_sum_out",   vif.frame_sum, EXP_SUM);

        // one 39-clock line (line 4): lose lock after two active lines, count an error
        b_valid = n_valid; b_done = n_done;
        drive_frame(4);
        check_eq("short_locked",    32'(vif.locked), 0);
        check_eq("short_err_cnt",   32'(vif.err_cnt), 1);
        check_eq("short_valid_cnt", n_valid - b_valid, 2 * T_H_RES);
        check_eq("short_done_cnt",  n_done - b_done, 1);
        drive_frame(-1);
        drive_frame(-1);
        check_eq("relock",        32'(vif.locked), 1);
        check_eq("relock_err",    32'(vif.err_cnt), 1);
        check_eq("sum_held",      vif.frame_sum, EXP_SUM);

        // Hsync stuck high: hold lock until the line counter saturates
        idle(1500);
        check_eq("to_before",  32'(vif.locked), 1);
        idle(600);
        check_eq("to_locked",  32'(vif.locked), 0);
        check_eq("to_err_cnt", 32'(vif.err_cnt), 1);
        check_eq("to_h_total", 32'(vif.h_total), T_LINE);

        drive_frame(-1);
        drive_frame(-1);
        drive_frame(-1);
        check_eq("to_relock", 32'(vif.locked), 1);

        // asynchronous reset in the middle of an active line
        for (int l = 0; l < 4; l++) drive_line(T_LINE, T_LINE, l < T_VSW);
        drive_line(T_LINE, 16, 1'b0);
        check_eq("mid_pix_valid", 32'(vif.pix_valid), 1);
        check_eq("mid_pix_x",     32'(vif.pix_x), 3);
        check_eq("mid_pix_y",     32'(vif.pix_y), 1);
        reset = 1'b1;
        #1;
        check_eq("arst_locked",    32'(vif.locked), 0);
        check_eq("arst_pix_valid", 32'(vif.pix_valid), 0);
        check_eq("arst_pix_x",     32'(vif.pix_x), 0);
        check_eq("arst_pix_rgb",   32'(vif.pix_rgb), 0);
        check_eq("arst_err_cnt",   32'(vif.err_cnt), 0);
        check_eq("arst_h_total",   32'(vif.h_total), 0);
        check_eq("arst_v_sync_w",  32'(vif.v_sync_w), 0);
        check_eq("arst_frame_sum", vif.frame_sum, 0);
        idle(2);
        reset = 1'b0;
        idle(5);
        drive_frame(-1);
        drive_frame(-1);
        drive_frame(-1);
        check_eq("post_rst_locked",  32'(vif.locked), 1);
        check_eq("post_rst_h_total", 32'(vif.h_total), T_LINE);
        check_eq("post_rst_v_total", 32'(vif.v_total), T_LINES);
        check_eq("post_rst_err_cnt", 32'(vif.err_cnt), 0);

        check_eq("pix_out_of_range", n_oob, 0);
        check_eq("pix_rgb_wrong",    n_bad_rgb, 0);
        check_eq("pix_leak_invalid", n_leak, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
